rec_play_slot_ctrl: RTL and testbench

Parametrised successor to the top-level record/play control FSM. It manages N_SLOT independent recording slots carved from one SRAM address space and stores a recorded length per slot. It drives enables for the recorder and DSP/player, ends playback automatically at the recorded length (or loops), and keeps a saturating seconds timer. It sits between the key inputs and the AudRecorder/AudDSP/AudPlayer instances.

---
 rtl/rec_play_pkg.sv | 23 ++
 rtl/rec_play_slot_ctrl_sec_timer.sv | 38 +++
 rtl/rec_play_slot_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_rec_play_slot_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rec_play_pkg.sv
// Shared types and width helpers for the record/play slot controller.
package rec_play_pkg;

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_IDLE       = 3'd1,
    S_RECD       = 3'd2,
    S_RECD_PAUSE = 3'd3,
    S_PLAY       = 3'd4,
    S_PLAY_PAUSE = 3'd5
  } state_e;

  // Slot-select width; a single slot still gets a 1-bit select port.
  function automatic int unsigned calc_sw(input int unsigned n_slot);
    return (n_slot > 1) ? unsigned'($clog2(n_slot)) : 1;
  endfunction

  // Offset-within-slot width: the address bits left after the slot index.
  function automatic int unsigned calc_off_w(input int unsigned addr_w, input int unsigned n_slot);
    return addr_w - unsigned'($clog2(n_slot));
  endfunction

endpackage

// File: rtl/rec_play_slot_ctrl_sec_timer.sv
// Saturating seconds counter driven by a cycle prescaler; holds when not running.
module sec_timer #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned SEC_W  = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_clear,
  output logic [SEC_W-1:0] o_seconds
);

  localparam int unsigned TW = (CLK_HZ > 1) ? unsigned'($clog2(CLK_HZ)) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);

  logic [TW-1:0]    tick_q;
  logic [SEC_W-1:0] sec_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_q <= '0;
      sec_q  <= '0;
    end else if (i_clear) begin
      tick_q <= '0;
      sec_q  <= '0;
    end else if (i_run) begin
      if (tick_q == TICK_LAST) begin
        tick_q <= '0;
        if (sec_q != '1) sec_q <= sec_q + SEC_W'(1);
      end else begin
        tick_q <= tick_q + TW'(1);
      end
    end
  end

  assign o_seconds = sec_q;

endmodule

// File: rtl/rec_play_slot_ctrl.sv
// Record/play control FSM over N_SLOT equal SRAM slots with per-slot recorded lengths.
module rec_play_slot_ctrl
  import rec_play_pkg::*;
#(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned N_SLOT = 4,
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned SEC_W  = 7,
  localparam int unsigned SW    = calc_sw(N_SLOT),
  localparam int unsigned OFF_W = calc_off_w(ADDR_W, N_SLOT)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_i2c_done,
  input  logic              i_key_start,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic              i_rec_mode,
  input  logic              i_loop,
  input  logic [SW-1:0]     i_slot_sel,
  input  logic [OFF_W-1:0]  i_rec_offset,
  input  logic [OFF_W-1:0]  i_play_offset,
  output logic [2:0]        o_state,
  output logic              o_i2c_start,
  output logic              o_rec_en,
  output logic              o_rec_pause,
  output logic              o_play_en,
  output logic              o_play_pause,
  output logic              o_stop,
  output logic              o_play_restart,
  output logic [ADDR_W-1:0] o_slot_base,
  output logic [OFF_W-1:0]  o_play_len,
  output logic [N_SLOT-1:0] o_slot_valid,
  output logic [SEC_W-1:0]  o_seconds
);

  localparam logic [OFF_W-1:0] SLOT_MAX = '1;

  state_e              state_q, state_d;
  logic [2:0]          key_d1_q, edge_q;
  logic [SW-1:0]       slot_q, sel_c;
  logic [OFF_W-1:0]    len_q [N_SLOT];
  logic [N_SLOT-1:0]   valid_q;
  logic [OFF_W-1:0]    play_len_q;
  logic [ADDR_W-1:0]   slot_base_q;
  logic                i2c_start_q, rec_en_q, rec_pause_q, play_en_q, play_pause_q;
  logic                stop_q, restart_q;
  logic                start_e, pause_e, stop_e;
  logic                latch_c, commit_c, clear_c, restart_c, stop_c, run_c;

  // Key edge detect; bit order is {stop, pause, start}.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      key_d1_q <= '0;
      edge_q   <= '0;
    end else begin
      key_d1_q <= {i_key_stop, i_key_pause, i_key_start};
      edge_q   <= {i_key_stop, i_key_pause, i_key_start} & ~key_d1_q;
    end
  end

  assign sel_c = (N_SLOT > 1) ? i_slot_sel : '0;

  // Next-state decode with stop > pause > start priority on simultaneous edges.
  always_comb begin
    state_d   = state_q;
    latch_c   = 1'b0;
    commit_c  = 1'b0;
    clear_c   = 1'b0;
    restart_c = 1'b0;
    stop_e    = edge_q[2];
    pause_e   = edge_q[1] & ~edge_q[2];
    start_e   = edge_q[0] & ~edge_q[1] & ~edge_q[2];
    case (state_q)
      S_INIT: if (i_i2c_done) state_d = S_IDLE;
      S_IDLE: begin
        if (start_e) begin
          latch_c = 1'b1;
          if (i_rec_mode) begin
            state_d = S_RECD;
            clear_c = 1'b1;
          end else if (valid_q[sel_c]) begin
            state_d = S_PLAY;
            clear_c = 1'b1;
          end
        end
      end
      S_RECD: begin
        if (stop_e || (i_rec_offset == SLOT_MAX)) begin
          state_d  = S_IDLE;
          commit_c = 1'b1;
        end else if (pause_e) begin
          state_d = S_RECD_PAUSE;
        end
      end
      S_RECD_PAUSE: begin
        if (stop_e) begin
          state_d  = S_IDLE;
          commit_c = 1'b1;
        end else if (start_e) begin
          state_d = S_RECD;
        end
      end
      S_PLAY: begin
        if (stop_e) begin
          state_d = S_IDLE;
        end else if (pause_e) begin
          state_d = S_PLAY_PAUSE;
        end else if (i_play_offset >= len_q[slot_q]) begin
          if (i_loop) begin
            restart_c = 1'b1;
            clear_c   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_PLAY_PAUSE: begin
        if (stop_e) state_d = S_IDLE;
        else if (start_e) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase
    stop_c = (state_d == S_IDLE) &&
             ((state_q == S_RECD) || (state_q == S_RECD_PAUSE) ||
              (state_q == S_PLAY) || (state_q == S_PLAY_PAUSE));
  end

  // State, slot bookkeeping and registered outputs aligned with the state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_INIT;
      slot_q       <= '0;
      valid_q      <= '0;
      play_len_q   <= '0;
      slot_base_q  <= '0;
      i2c_start_q  <= 1'b1;
      rec_en_q     <= 1'b0;
      rec_pause_q  <= 1'b0;
      play_en_q    <= 1'b0;
      play_pause_q <= 1'b0;
      stop_q       <= 1'b0;
      restart_q    <= 1'b0;
      for (int i = 0; i < int'(N_SLOT); i++) len_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      i2c_start_q  <= (state_d == S_INIT);
      rec_en_q     <= (state_d == S_RECD);
      rec_pause_q  <= (state_d == S_RECD_PAUSE);
      play_en_q    <= (state_d == S_PLAY);
      play_pause_q <= (state_d == S_PLAY_PAUSE);
      stop_q       <= stop_c;
      restart_q    <= restart_c;
      if (latch_c) begin
        slot_q      <= sel_c;
        play_len_q  <= len_q[sel_c];
        slot_base_q <= ADDR_W'(sel_c) << OFF_W;
      end
      if (commit_c) begin
        len_q[slot_q]   <= i_rec_offset;
        valid_q[slot_q] <= (i_rec_offset != '0);
        play_len_q      <= i_rec_offset;
      end
    end
  end

  assign run_c = (state_q == S_RECD) || (state_q == S_PLAY);

  sec_timer #(
    .CLK_HZ(CLK_HZ),
    .SEC_W (SEC_W)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (run_c),
    .i_clear  (clear_c),
    .o_seconds(o_seconds)
  );

  assign o_state        = state_q;
  assign o_i2c_start    = i2c_start_q;
  assign o_rec_en       = rec_en_q;
  assign o_rec_pause    = rec_pause_q;
  assign o_play_en      = play_en_q;
  assign o_play_pause   = play_pause_q;
  assign o_stop         = stop_q;
  assign o_play_restart = restart_q;
  assign o_slot_base    = slot_base_q;
  assign o_play_len     = play_len_q;
  assign o_slot_valid   = valid_q;

endmodule

// File: tb/tb_rec_play_slot_ctrl.sv
// Directed bench: main instance (CLK_HZ=10) plus a SEC_W=2 twin fed the same stimulus.
module tb_rec_play_slot_ctrl;

  logic        clk = 1'b0;
  logic        rst, i2c_done, k_start, k_pause, k_stop, rec_mode, loop_en;
  logic [1:0]  sel;
  logic [17:0] rec_off, play_off;

  logic [2:0]  state;
  logic        i2c_start, rec_en, rec_pause, play_en, play_pause, stop_p, restart_p;
  logic [19:0] slot_base;
  logic [17:0] play_len;
  logic [3:0]  valid;
  logic [6:0]  seconds;

  logic [2:0]  s_state;
  logic        s_i2c_start, s_rec_en, s_rec_pause, s_play_en, s_play_pause, s_stop, s_restart;
  logic [19:0] s_slot_base;
  logic [17:0] s_play_len;
  logic [3:0]  s_valid;
  logic [1:0]  s_seconds;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rec_play_slot_ctrl #(.ADDR_W(20), .N_SLOT(4), .CLK_HZ(10), .SEC_W(7)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_i2c_done(i2c_done),
    .i_key_start(k_start), .i_key_pause(k_pause), .i_key_stop(k_stop),
    .i_rec_mode(rec_mode), .i_loop(loop_en), .i_slot_sel(sel),
    .i_rec_offset(rec_off), .i_play_offset(play_off),
    .o_state(state), .o_i2c_start(i2c_start), .o_rec_en(rec_en), .o_rec_pause(rec_pause),
    .o_play_en(play_en), .o_play_pause(play_pause), .o_stop(stop_p),
    .o_play_restart(restart_p), .o_slot_base(slot_base), .o_play_len(play_len),
    .o_slot_valid(valid), .o_seconds(seconds)
  );

  rec_play_slot_ctrl #(.ADDR_W(20), .N_SLOT(4), .CLK_HZ(10), .SEC_W(2)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_i2c_done(i2c_done),
    .i_key_start(k_start), .i_key_pause(k_pause), .i_key_stop(k_stop),
    .i_rec_mode(rec_mode), .i_loop(loop_en), .i_slot_sel(sel),
    .i_rec_offset(rec_off), .i_play_offset(play_off),
    .o_state(s_state), .o_i2c_start(s_i2c_start), .o_rec_en(s_rec_en),
    .o_rec_pause(s_rec_pause), .o_play_en(s_play_en), .o_play_pause(s_play_pause),
    .o_stop(s_stop), .o_play_restart(s_restart), .o_slot_base(s_slot_base),
    .o_play_len(s_play_len), .o_slot_valid(s_valid), .o_seconds(s_seconds)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Key held for one cycle; the state register reflects it after the second edge.
  task automatic press_start();
    k_start = 1'b1; step(1); k_start = 1'b0; step(1);
  endtask

  task automatic press_stop();
    k_stop = 1'b1; step(1); k_stop = 1'b0; step(1);
  endtask

  initial begin
    rst = 1'b1; i2c_done = 1'b0; k_start = 1'b0; k_pause = 1'b0; k_stop = 1'b0;
    rec_mode = 1'b0; loop_en = 1'b0; sel = 2'd0; rec_off = '0; play_off = '0;
    step(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_i2c_start", 32'(i2c_start), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_seconds", 32'(seconds), 32'd0);
    check("rst_stop", 32'(stop_p), 32'd0);

    rst = 1'b0; i2c_done = 1'b1;
    step(1);
    check("init_to_idle", 32'(state), 32'd1);
    check("i2c_start_low", 32'(i2c_start), 32'd0);

    // Record slot 2, stop at offset 1000.
    sel = 2'd2; rec_mode = 1'b1;
    press_start();
    check("rec2_state", 32'(state), 32'd2);
    check("rec2_rec_en", 32'(rec_en), 32'd1);
    check("rec2_base", 32'(slot_base), 32'h80000);
    sel = 2'd3; rec_off = 18'd1000;
    press_stop();
    check("rec2_stop_state", 32'(state), 32'd1);
    check("rec2_stop_pulse", 32'(stop_p), 32'd1);
    check("rec2_valid", 32'(valid), 32'h4);
    check("rec2_len", 32'(play_len), 32'd1000);
    check("rec2_sel_ignored", 32'(slot_base), 32'h80000);
    step(1);
    check("stop_one_cycle", 32'(stop_p), 32'd0);
    rec_off = '0;

    // Play request on empty slot 1 is refused.
    sel = 2'd1; rec_mode = 1'b0;
    press_start();
    check("empty_state", 32'(state), 32'd1);
    step(1);
    check("empty_state_hold", 32'(state), 32'd1);
    check("empty_no_stop", 32'(stop_p), 32'd0);
    check("empty_no_play_en", 32'(play_en), 32'd0);

    // Play slot 2: 35 running cycles, 20 paused, 5 running.
    sel = 2'd2; play_off = '0; loop_en = 1'b0;
    press_start();
    check("play_state", 32'(state), 32'd4);
    check("play_en", 32'(play_en), 32'd1);
    check("play_len", 32'(play_len), 32'd1000);
    check("play_sec_clear", 32'(seconds), 32'd0);
    step(33);
    k_pause = 1'b1; step(1); k_pause = 1'b0; step(1);
    check("pause_state", 32'(state), 32'd5);
    check("pause_flag", 32'(play_pause), 32'd1);
    check("sec_after_35", 32'(seconds), 32'd3);
    step(18);
    press_start();
    check("resume_state", 32'(state), 32'd4);
    check("sec_held_pause", 32'(seconds), 32'd3);
    step(4);
    check("sec_after_39", 32'(seconds), 32'd3);
    step(1);
    check("sec_after_40", 32'(seconds), 32'd4);
    check("sat_seconds", 32'(s_seconds), 32'd3);
    play_off = 18'd1000;
    step(1);
    check("play_end_state", 32'(state), 32'd1);
    check("play_end_stop", 32'(stop_p), 32'd1);
    check("play_end_no_restart", 32'(restart_p), 32'd0);

    // Looping playback restarts and clears seconds.
    play_off = '0; loop_en = 1'b1;
    press_start();
    check("loop_state", 32'(state), 32'd4);
    step(12);
    check("loop_sec_1", 32'(seconds), 32'd1);
    play_off = 18'd1000;
    step(1);
    check("loop_restart", 32'(restart_p), 32'd1);
    check("loop_state_keep", 32'(state), 32'd4);
    check("loop_sec_clear", 32'(seconds), 32'd0);
    check("loop_no_stop", 32'(stop_p), 32'd0);
    play_off = '0;
    step(1);
    check("loop_restart_low", 32'(restart_p), 32'd0);
    loop_en = 1'b0;
    press_stop();
    check("loop_stop_state", 32'(state), 32'd1);
    check("loop_stop_pulse", 32'(stop_p), 32'd1);

    // Pause and stop together while recording slot 0: stop wins.
    sel = 2'd0; rec_mode = 1'b1;
    press_start();
    check("rec0_state", 32'(state), 32'd2);
    rec_off = 18'd500;
    k_pause = 1'b1; k_stop = 1'b1; step(1); k_pause = 1'b0; k_stop = 1'b0; step(1);
    check("pstop_state", 32'(state), 32'd1);
    check("pstop_pulse", 32'(stop_p), 32'd1);
    check("pstop_valid", 32'(valid), 32'h5);
    check("pstop_len", 32'(play_len), 32'd500);
    rec_off = '0;

    // Recording slot 3 auto-stops at the slot end.
    sel = 2'd3;
    press_start();
    check("rec3_state", 32'(state), 32'd2);
    check("rec3_base", 32'(slot_base), 32'hC0000);
    rec_off = 18'h3FFFF;
    step(1);
    check("auto_state", 32'(state), 32'd1);
    check("auto_stop", 32'(stop_p), 32'd1);
    check("auto_len", 32'(play_len), 32'h3FFFF);
    check("auto_valid", 32'(valid), 32'hD);
    rec_off = '0;

    // Reset mid-recording clears everything.
    sel = 2'd1;
    press_start();
    check("rec1_state", 32'(state), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_rec_en", 32'(rec_en), 32'd0);
    check("mid_rst_len", 32'(play_len), 32'd0);
    step(1);
    rst = 1'b0;
    step(1);
    check("post_rst_idle", 32'(state), 32'd1);
    sel = 2'd2; rec_mode = 1'b0;
    press_start();
    check("post_rst_no_play", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
